keypad_scanner: RTL and testbench

//   Scans the 4x4 matrix keypad by driving one column low at a time and sampling the 4 rows.

---
 rtl/keypad_scanner.sv | 95 +++++++++
 tb/tb_keypad_scanner.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with row synchronizer and multi-scan debounce.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk_ctrl,
  input  logic        reset_n,
  input  logic        scan_en,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [15:0] keys,
  output logic        keys_update
);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX      = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DRIVE, COMPARE} state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_c;
  logic [SW-1:0] r_settle;
  logic [DW-1:0] r_stable;
  logic [15:0]   r_shadow, r_last, r_keys;
  logic          r_upd;
  logic [3:0]    r_sync1, r_sync2;
  logic          w_sample, w_abort, w_match, w_publish;
  logic [DW-1:0] w_stable_nx;
  logic [15:0]   w_last_nx;

  assign w_abort     = r_state == DRIVE && !scan_en;
  assign w_sample    = r_state == DRIVE && scan_en && r_settle == SETTLE_LAST;
  assign w_match     = r_shadow == r_last;
  assign w_stable_nx = w_match ? ((r_stable == DB_MAX) ? DB_MAX : r_stable + 1'b1) : DW'(1);
  assign w_last_nx   = w_match ? r_last : r_shadow;
  assign w_publish   = w_stable_nx == DB_MAX && w_last_nx != r_keys;

  always_ff @(posedge clk_ctrl or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nx;

  always_comb begin
    w_state_nx = IDLE;
    case (r_state)
      IDLE:    w_state_nx = scan_en ? DRIVE : IDLE;
      DRIVE:   w_state_nx = !scan_en ? IDLE : (w_sample && r_c == 2'd3) ? COMPARE : DRIVE;
      COMPARE: w_state_nx = scan_en ? DRIVE : IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Column drive decodes straight from state so reset releases the columns without a clock.
  always_comb begin
    col_n       = (r_state == DRIVE) ? ~(4'b0001 << r_c) : 4'b1111;
    keys        = r_keys;
    keys_update = r_upd;
  end

  always_ff @(posedge clk_ctrl or negedge reset_n)
    if (!reset_n) begin
      r_sync1  <= 4'hF;
      r_sync2  <= 4'hF;
      r_c      <= '0;
      r_settle <= '0;
      r_stable <= '0;
      r_shadow <= 16'hFFFF;
      r_last   <= 16'hFFFF;
      r_keys   <= 16'hFFFF;
      r_upd    <= 1'b0;
    end else begin
      r_sync1 <= row_n;
      r_sync2 <= r_sync1;
      r_upd   <= 1'b0;
      if (w_abort) begin
        r_shadow <= 16'hFFFF;
        r_stable <= '0;
        r_c      <= '0;
        r_settle <= '0;
      end else if (r_state == DRIVE) begin
        r_settle <= w_sample ? '0 : r_settle + 1'b1;
        if (w_sample) begin
          r_shadow[4*r_c +: 4] <= r_sync2;
          r_c                  <= r_c + 2'd1;
        end
      end else if (r_state == COMPARE) begin
        r_last   <= w_last_nx;
        r_stable <= w_stable_nx;
        if (w_publish) begin
          r_keys <= w_last_nx;
          r_upd  <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce latency, chords, bounce, abort and reset.
`timescale 1ns/1ps
module tb_keypad_scanner;
  logic        clk_ctrl = 1'b0;
  logic        reset_n  = 1'b0;
  logic        scan_en  = 1'b0;
  logic [3:0]  row_n    = 4'hF;
  logic [3:0]  col_n;
  logic [15:0] keys;
  logic        keys_update;
  logic [15:0] pressed = 16'h0000;
  int n_cmp = 0, n_err = 0, n_pulse = 0, p0 = 0;

  typedef struct { logic [15:0] press; logic [15:0] keys; int pulses; } vec_t;
  vec_t vecs[8];

  keypad_scanner dut (
    .clk_ctrl(clk_ctrl), .reset_n(reset_n), .scan_en(scan_en), .row_n(row_n),
    .col_n(col_n), .keys(keys), .keys_update(keys_update)
  );

  always #5 clk_ctrl = ~clk_ctrl;

  function automatic logic [3:0] rows_of(input logic [15:0] p, input logic [3:0] col);
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 4; c++) if (!col[c]) r &= ~p[4*c +: 4];
    return r;
  endfunction

  always @(posedge clk_ctrl) row_n <= rows_of(pressed, col_n);
  always @(posedge clk_ctrl) if (keys_update === 1'b1) n_pulse++;
  always @(negedge clk_ctrl)
    if ($countones(~col_n) > 1) begin
      n_err++;
      $display("FAIL col_overlap: col_n=%b, at most one column may be low", col_n);
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_col(input logic [3:0] v);
    for (int i = 0; i < 200 && col_n !== v; i++) @(negedge clk_ctrl);
    check("wait_col", {28'd0, col_n}, {28'd0, v});
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16'hFFFF, 1};
    vecs[1] = '{16'h8421, 16'h7BDE, 1};
    vecs[2] = '{16'hF421, 16'h0BDE, 1};
    vecs[3] = '{16'hF421, 16'h0BDE, 0};
    vecs[4] = '{16'h1000, 16'hEFFF, 1};
    vecs[5] = '{16'h4444, 16'hBBBB, 1};
    vecs[6] = '{16'hFFFF, 16'h0000, 1};
    vecs[7] = '{16'h0000, 16'hFFFF, 1};

    repeat (3) @(negedge clk_ctrl);
    check("rst col_n", col_n, 4'hF);
    check("rst keys", keys, 16'hFFFF);
    check("rst upd", keys_update, 0);

    pressed = 16'h0001; reset_n = 1'b1; scan_en = 1'b1;
    @(posedge clk_ctrl); #1 check("E0 col_n", col_n, 4'b1110);
    repeat (3) @(posedge clk_ctrl); #1 check("E3 col_n", col_n, 4'b1110);
    @(posedge clk_ctrl); #1 check("E4 col_n", col_n, 4'b1101);
    repeat (12) @(posedge clk_ctrl); #1 check("E16 col_n", col_n, 4'b1111);
    @(posedge clk_ctrl); #1 check("E17 col_n", col_n, 4'b1110);
    repeat (33) @(posedge clk_ctrl); #1;
    check("E50 keys", keys, 16'hFFFF);
    check("E50 upd", keys_update, 0);
    p0 = n_pulse;
    @(posedge clk_ctrl); #1;
    check("E51 keys", keys, 16'hFFFE);
    check("E51 upd", keys_update, 1);
    @(posedge clk_ctrl); #1 check("E52 upd", keys_update, 0);
    repeat (34) @(posedge clk_ctrl); #1;
    check("held keys", keys, 16'hFFFE);
    check("held pulses", n_pulse - p0, 1);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk_ctrl);
      p0 = n_pulse;
      pressed = vecs[i].press;
      repeat (85) @(negedge clk_ctrl);
      check($sformatf("vec%0d keys", i), keys, vecs[i].keys);
      check($sformatf("vec%0d pulses", i), n_pulse - p0, vecs[i].pulses);
    end

    p0 = n_pulse;
    for (int s = 0; s < 10; s++) begin
      pressed = (s % 2 == 0) ? 16'h0001 : 16'h0000;
      repeat (17) @(negedge clk_ctrl);
    end
    pressed = 16'h0000;
    check("bounce keys", keys, 16'hFFFF);
    check("bounce pulses", n_pulse - p0, 0);

    pressed = 16'h0020;
    repeat (85) @(negedge clk_ctrl);
    check("pre-abort keys", keys, 16'hFFDF);
    pressed = 16'h0000;
    wait_col(4'b1011);
    scan_en = 1'b0;
    @(posedge clk_ctrl); #1 check("abort col_n", col_n, 4'hF);
    p0 = n_pulse;
    repeat (20) @(negedge clk_ctrl);
    check("idle keys", keys, 16'hFFDF);
    check("idle col_n", col_n, 4'hF);
    check("idle pulses", n_pulse - p0, 0);
    scan_en = 1'b1;
    @(posedge clk_ctrl); #1 check("restart col_n", col_n, 4'b1110);
    repeat (50) @(posedge clk_ctrl); #1 check("restart E50 keys", keys, 16'hFFDF);
    @(posedge clk_ctrl); #1;
    check("restart E51 keys", keys, 16'hFFFF);
    check("restart E51 upd", keys_update, 1);

    @(negedge clk_ctrl);
    pressed = 16'h0001;
    repeat (85) @(negedge clk_ctrl);
    check("pre-reset keys", keys, 16'hFFFE);
    wait_col(4'b1101);
    #2 reset_n = 1'b0;
    #1;
    check("midrst col_n", col_n, 4'hF);
    check("midrst keys", keys, 16'hFFFF);
    check("midrst upd", keys_update, 0);
    @(negedge clk_ctrl);
    pressed = 16'h0000; scan_en = 1'b0; reset_n = 1'b1;
    repeat (5) @(negedge clk_ctrl);
    check("post-rst col_n", col_n, 4'hF);
    check("post-rst keys", keys, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
